// File: rtl/pattern_serializer.sv
// Serial stimulus transmitter for a `1001` sequence detector.
// Accepts a parallel pattern over a valid/ready handshake and shifts it out
// LSB first, optionally repeating it with a fixed zero gap between frames,
// while counting every (overlapping) `1001` it drives onto the line.
module pattern_serializer #(
    parameter int WIDTH = 11,
    parameter int GAP   = 2,
    parameter int REP_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [WIDTH-1:0]           load_data,
    input  logic [$clog2(WIDTH+1)-1:0] load_len,
    input  logic [REP_W-1:0]           load_repeat,
    output logic                       out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           match_cnt
);

    localparam int LEN_W = $clog2(WIDTH + 1);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pat_q, pat_d;       // captured pattern, reused per frame
    logic [WIDTH-1:0]   shift_q, shift_d;   // working copy, bit 0 is on the line
    logic [LEN_W-1:0]   len_q, len_d;       // effective frame length
    logic [REP_W-1:0]   rep_q, rep_d;       // extra frames requested
    logic [REP_W-1:0]   frame_q, frame_d;   // frames completed so far
    logic [LEN_W-1:0]   idx_q, idx_d;       // bit index inside the frame
    logic [GAP_W-1:0]   gap_q, gap_d;       // gap cycle counter
    logic [2:0]         hist_q, hist_d;     // previous three driven bits, newest in bit 0
    logic [CNT_W-1:0]   match_q, match_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   eff_len;
    logic [3:0]         window;             // last four driven bits, oldest in bit 3

    // Zero or oversize lengths mean a full-width frame.
    assign eff_len = (load_len == '0 || load_len > LEN_MAX) ? LEN_MAX : load_len;

    assign out        = (state_q == S_SHIFT) ? shift_q[0] : 1'b0;
    assign out_valid  = (state_q == S_SHIFT);
    assign busy       = (state_q != S_IDLE);
    assign load_ready = (state_q == S_IDLE) && !reset;
    assign done       = done_q;
    assign match_cnt  = match_q;
    assign window     = {hist_q, out};

    // Next-state logic: load capture, bit sequencing, gap timing and match counting.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        state_d = state_q;
        pat_d   = pat_q;
        shift_d = shift_q;
        len_d   = len_q;
        rep_d   = rep_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        hist_d  = hist_q;
        match_d = match_q;
        done_d  = 1'b0;

        // Gap zeros are part of what the detector sees, so they feed the history too.
        if (state_q != S_IDLE) begin
            hist_d = {hist_q[1:0], out};
            if (window == 4'b1001 && match_q != '1) begin
                match_d = match_q + CNT_W'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (load_valid && load_ready) begin
                    pat_d   = load_data;
                    shift_d = load_data;
                    len_d   = eff_len;
                    rep_d   = load_repeat;
                    frame_d = '0;
                    idx_d   = '0;
                    hist_d  = '0;
                    match_d = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d = shift_q >> 1;
                if (idx_q == len_q - LEN_W'(1)) begin
                    idx_d = '0;
                    if (frame_q != rep_q) begin
                        frame_d = frame_q + REP_W'(1);
                        shift_d = pat_q;
                        if (GAP > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_SHIFT;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset abandons any frame in flight and clears all counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            shift_q <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            frame_q <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            hist_q  <= '0;
            match_q <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            pat_q   <= pat_d;
            shift_q <= shift_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            hist_q  <= hist_d;
            match_q <= match_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: expected line values are queued
// when a load is driven and popped on every busy cycle. A second instance
// with GAP=0 and a 2-bit counter covers back-to-back frames and saturation.
module tb_pattern_serializer;

    localparam int GAP_M = 2;

    logic        clk = 1'b0;
    logic        reset;

    logic        load_valid, load_ready, out, out_valid, busy, done;
    logic [10:0] load_data;
    logic [3:0]  load_len, load_repeat;
    logic [7:0]  match_cnt;

    logic        s_valid, s_ready, s_out, s_out_valid, s_busy, s_done;
    logic [10:0] s_data;
    logic [3:0]  s_len, s_rep;
    logic [1:0]  s_match;

    logic [1:0]  exp_q[$];   // {out_valid, out} per busy cycle, main instance
    logic [1:0]  sat_q[$];   // same for the saturation instance
    int          n_cmp = 0;
    int          n_bad = 0;
    int          busy_cnt = 0;
    int          s_busy_cnt = 0;

    always #5 clk = ~clk;

    pattern_serializer #(.WIDTH(11), .GAP(GAP_M), .REP_W(4), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_len(load_len), .load_repeat(load_repeat),
        .out(out), .out_valid(out_valid), .busy(busy), .done(done), .match_cnt(match_cnt)
    );

    pattern_serializer #(.WIDTH(11), .GAP(0), .REP_W(4), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .load_valid(s_valid), .load_ready(s_ready),
        .load_data(s_data), .load_len(s_len), .load_repeat(s_rep),
        .out(s_out), .out_valid(s_out_valid), .busy(s_busy), .done(s_done), .match_cnt(s_match)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard pop for the main instance.
    always @(negedge clk) begin : mon_main
        logic [1:0] e;
        if (!reset && busy) begin
            busy_cnt++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("line", 32'({out_valid, out}), 32'(e));
            end
        end
    end

    // Scoreboard pop for the saturation instance.
    always @(negedge clk) begin : mon_sat
        logic [1:0] e;
        if (!reset && s_busy) begin
            s_busy_cnt++;
            check("sat_sb_nonempty", 32'(sat_q.size() != 0), 32'(1));
            if (sat_q.size() != 0) begin
                e = sat_q.pop_front();
                check("sat_line", 32'({s_out_valid, s_out}), 32'(e));
            end
        end
    end

    // Reference model: builds the driven stream and the expected 1001 count.
    task automatic push_frames(input logic [10:0] d, input int len, input int rep, input int gap,
                               input int cmax, input bit sat, output int em, output int eb);
        int         eff;
        logic [3:0] h;
        logic       v;
        eff = (len == 0 || len > 11) ? 11 : len;
        h   = '0;
        em  = 0;
        eb  = 0;
        for (int f = 0; f <= rep; f++) begin
            for (int b = 0; b < eff; b++) begin
                v = d[b];
                if (sat) sat_q.push_back({1'b1, v}); else exp_q.push_back({1'b1, v});
                h = {h[2:0], v};
                if (h == 4'b1001 && em < cmax) em++;
                eb++;
            end
            if (f < rep) begin
                for (int g = 0; g < gap; g++) begin
                    if (sat) sat_q.push_back(2'b00); else exp_q.push_back(2'b00);
                    h = {h[2:0], 1'b0};
                    eb++;
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge of the first bit cycle (k+1).
    task automatic start_load(input bit sat, input logic [10:0] d, input int len, input int rep,
                              input bit hold, output int em, output int eb);
        int n;
        logic rdy;
        n   = 0;
        rdy = sat ? s_ready : load_ready;
        while (!rdy && n < 100) begin
            @(negedge clk);
            n++;
            rdy = sat ? s_ready : load_ready;
        end
        check("ready_wait", 32'(rdy), 32'(1));
        if (sat) begin
            s_data = d; s_len = 4'(len); s_rep = 4'(rep); s_valid = 1'b1;
            push_frames(d, len, rep, 0, 3, 1'b1, em, eb);
            s_busy_cnt = 0;
        end else begin
            load_data = d; load_len = 4'(len); load_repeat = 4'(rep); load_valid = 1'b1;
            push_frames(d, len, rep, GAP_M, 255, 1'b0, em, eb);
            busy_cnt = 0;
        end
        @(negedge clk);
        if (sat) begin
            check("sat_first_bit", 32'({s_busy, s_out}), 32'({1'b1, d[0]}));
            if (!hold) s_valid = 1'b0;
        end else begin
            check("first_bit", 32'({busy, out}), 32'({1'b1, d[0]}));
            if (!hold) load_valid = 1'b0;
        end
    endtask

    // Called at the k+1 negedge; returns at the negedge of the done cycle.
    task automatic wait_done(input bit sat, input int eb, input int em, input int pending);
        int n;
        bit seen;
        n    = 1;
        seen = 1'b0;
        while (n < eb + 20) begin
            if (sat ? s_done : done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(seen), 32'(1));
        check("done_cycle", 32'(n), 32'(eb + 1));
        if (sat) begin
            check("sat_busy_cycles", 32'(s_busy_cnt), 32'(eb));
            check("sat_match_cnt", 32'(s_match), 32'(em));
            check("sat_sb_left", 32'(sat_q.size()), 32'(pending));
            check("sat_ready_in_done", 32'(s_ready), 32'(1));
        end else begin
            check("busy_cycles", 32'(busy_cnt), 32'(eb));
            check("match_cnt", 32'(match_cnt), 32'(em));
            check("sb_left", 32'(exp_q.size()), 32'(pending));
            check("ready_in_done", 32'(load_ready), 32'(1));
        end
    endtask

    initial begin
        int em, eb, em2, eb2;
        logic [10:0] pat_b;

        reset = 1'b1;
        load_valid = 1'b0; load_data = '0; load_len = '0; load_repeat = '0;
        s_valid = 1'b0; s_data = '0; s_len = '0; s_rep = '0;

        // Reset state.
        #2;
        check("rst_ready", 32'(load_ready), 32'(0));
        check("rst_outs", 32'({out, out_valid, busy, done}), 32'(0));
        check("rst_match", 32'(match_cnt), 32'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_rst", 32'(load_ready), 32'(1));
        @(negedge clk);

        // Single frame: 1,0,0,1,1,0,0,1,0,0,1 -> three matches.
        start_load(1'b0, 11'b10010011001, 11, 0, 1'b0, em, eb);
        wait_done(1'b0, eb, em, 0);
        check("single_match_const", 32'(match_cnt), 32'(3));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'(0));
        check("match_hold_idle", 32'(match_cnt), 32'(3));

        // Repeat with gap: boundary 1,0,0,1 across the gap adds a match.
        start_load(1'b0, 11'b10010011001, 11, 1, 1'b0, em, eb);
        wait_done(1'b0, eb, em, 0);
        check("repeat_busy_const", 32'(busy_cnt), 32'(24));
        check("repeat_match_const", 32'(match_cnt), 32'(7));

        // Short length, zero length, oversize length.
        start_load(1'b0, 11'b11100001001, 4, 0, 1'b0, em, eb);
        wait_done(1'b0, eb, em, 0);
        check("short_match_const", 32'(match_cnt), 32'(1));
        start_load(1'b0, 11'b01101001001, 0, 0, 1'b0, em, eb);
        wait_done(1'b0, eb, em, 0);
        start_load(1'b0, 11'b10011001001, 15, 2, 1'b0, em, eb);
        wait_done(1'b0, eb, em, 0);

        // A few random loads.
        for (int i = 0; i < 4; i++) begin
            start_load(1'b0, 11'($urandom), int'($urandom_range(0, 11)),
                       int'($urandom_range(0, 2)), 1'b0, em, eb);
            wait_done(1'b0, eb, em, 0);
        end

        // Reset mid-frame: everything clears at once and no done follows.
        start_load(1'b0, 11'b10010011001, 11, 0, 1'b0, em, eb);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_outs", 32'({out, out_valid, busy}), 32'(0));
        check("midrst_match", 32'(match_cnt), 32'(0));
        check("midrst_ready", 32'(load_ready), 32'(0));
        exp_q.delete();
        @(negedge clk);
        check("midrst_no_done", 32'(done), 32'(0));
        reset = 1'b0;
        #1;
        check("midrst_ready_rel", 32'(load_ready), 32'(1));
        @(negedge clk);
        check("midrst_idle", 32'({busy, done}), 32'(0));
        start_load(1'b0, 11'b10010011001, 11, 0, 1'b0, em, eb);
        wait_done(1'b0, eb, em, 0);

        // Reset coinciding with a load: the load is dropped.
        @(negedge clk);
        load_data = 11'h7ff; load_len = 4'd3; load_repeat = '0;
        load_valid = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_vs_load_idle", 32'(busy), 32'(0));

        // Back-to-back: valid held, second pattern accepted in the done cycle.
        pat_b = 11'b01100100111;
        start_load(1'b0, 11'b10010011001, 11, 0, 1'b1, em, eb);
        load_data = pat_b; load_len = 4'd11; load_repeat = '0;
        push_frames(pat_b, 11, 0, GAP_M, 255, 1'b0, em2, eb2);
        wait_done(1'b0, eb, em, eb2);
        busy_cnt = 0;
        @(negedge clk);
        load_valid = 1'b0;
        check("b2b_no_bubble", 32'({busy, out}), 32'({1'b1, pat_b[0]}));
        wait_done(1'b0, eb2, em2, 0);

        // Saturation on the 2-bit counter, GAP=0 repeat.
        @(negedge clk);
        start_load(1'b1, 11'b00_1001001001, 10, 1, 1'b0, em, eb);
        wait_done(1'b1, eb, em, 0);
        check("sat_match_const", 32'(s_match), 32'(3));
        check("sat_busy_const", 32'(s_busy_cnt), 32'(20));

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
